// File: rtl/ldpc_encoder.sv
// Serial (12,4) LDPC encoder: computes one parity bit per clock, then presents the codeword with a valid/ready handoff.
// Optional macro LDPC_ENC_SELFCHECK_EN adds a syndrome check on each loaded codeword, reported on chk_err.
module ldpc_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  msg_in,
    input  logic        msg_valid,
    output logic        msg_ready,
    output logic [11:0] code,
    output logic        code_valid,
    input  logic        code_ready,
    output logic        busy,
    output logic        chk_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  msg_q, msg_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [11:0] work_q, work_d;
    logic [11:0] code_q, code_d;
    logic        valid_q, valid_d;
    logic        ready_q, ready_d;

    logic        par_bit;
    logic [3:0]  par_pos;

    // Parity bit and its codeword position for the current counter step.
    always_comb begin
        par_bit = 1'b0;
        par_pos = 4'd11;
        case (cnt_q)
            3'd0: begin par_bit = msg_q[1] ^ msg_q[2] ^ msg_q[3]; par_pos = 4'd11; end
            3'd1: begin par_bit = msg_q[0] ^ msg_q[2];            par_pos = 4'd10; end
            3'd2: begin par_bit = msg_q[0];                       par_pos = 4'd9;  end
            3'd3: begin par_bit = msg_q[1] ^ msg_q[2] ^ msg_q[3]; par_pos = 4'd8;  end
            3'd4: begin par_bit = msg_q[1] ^ msg_q[2] ^ msg_q[3]; par_pos = 4'd7;  end
            3'd5: begin par_bit = msg_q[2];                       par_pos = 4'd6;  end
            3'd6: begin par_bit = msg_q[0] ^ msg_q[1] ^ msg_q[2]; par_pos = 4'd5;  end
            default: begin par_bit = msg_q[0] ^ msg_q[1] ^ msg_q[2]; par_pos = 4'd3; end
        endcase
    end

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        code_d  = code_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (msg_valid && ready_q) begin
                    msg_d   = msg_in;
                    cnt_d   = 3'd0;
                    // Systematic bits go in at acceptance; parity slots start cleared.
                    work_d  = {7'b0, msg_in[3], 1'b0, msg_in[2:0]};
                    state_d = CALC;
                end
            end
            CALC: begin
                work_d[par_pos] = par_bit;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    code_d  = work_d;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (code_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered ready stays low through reset and rises on the first edge after release.
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            msg_q   <= 4'd0;
            cnt_q   <= 3'd0;
            work_q  <= 12'd0;
            code_q  <= 12'd0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign msg_ready  = ready_q;
    assign code       = code_q;
    assign code_valid = valid_q;
    assign busy       = (state_q != IDLE);

`ifdef LDPC_ENC_SELFCHECK_EN
    // One mask per parity check; each check XORs the masked codeword bits.
    localparam logic [11:0] H_MASK [8] = '{
        12'h880, 12'hA30, 12'h441, 12'h422,
        12'h604, 12'h24A, 12'h1C4, 12'h119
    };

    logic [7:0] syn;
    logic       chk_q, chk_d;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_syn
            assign syn[gi] = ^(code_d & H_MASK[gi]);
        end
    endgenerate

    always_comb begin
        chk_d = chk_q;
        if (state_q == CALC && cnt_q == 3'd7) begin
            chk_d = |syn;
        end else if (state_q == DONE && code_ready) begin
            chk_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= 1'b0;
        end else begin
            chk_q <= chk_d;
        end
    end

    assign chk_err = chk_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_ldpc_encoder.sv
// Directed self-checking bench for ldpc_encoder: encodings, latency, handshake hold, mid-CALC reset, single-bit-error decode.
module tb_ldpc_encoder;

    logic        clk;
    logic        rst_n;
    logic [3:0]  msg_in;
    logic        msg_valid;
    logic        msg_ready;
    logic [11:0] code;
    logic        code_valid;
    logic        code_ready;
    logic        busy;
    logic        chk_err;

    int errors = 0;
    int checks = 0;

    ldpc_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .msg_in     (msg_in),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .code       (code),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .busy       (busy),
        .chk_err    (chk_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    localparam logic [11:0] H [8] = '{
        12'h880, 12'hA30, 12'h441, 12'h422,
        12'h604, 12'h24A, 12'h1C4, 12'h119
    };

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] synd(input logic [11:0] c);
        logic [7:0] s;
        for (int k = 0; k < 8; k++) s[k] = ^(c & H[k]);
        return s;
    endfunction

    function automatic logic [3:0] decode(input logic [11:0] r);
        logic [11:0] fixed;
        logic [11:0] e;
        logic [7:0]  s;
        fixed = r;
        s = synd(r);
        if (s != 8'd0) begin
            for (int j = 0; j < 12; j++) begin
                e = 12'd1 << j;
                if (synd(e) == s) fixed = r ^ e;
            end
        end
        return {fixed[4], fixed[2], fixed[1], fixed[0]};
    endfunction

    function automatic logic [11:0] enc_ref(input logic [3:0] m);
        logic p1, p2, p3;
        p1 = m[1] ^ m[2] ^ m[3];
        p2 = m[0] ^ m[1] ^ m[2];
        p3 = m[0] ^ m[2];
        return {p1, p3, m[0], p1, p1, m[2], p2, m[3], p2, m[2], m[1], m[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one message and walk the 8 CALC edges, checking latency and ready/busy on each.
    task automatic encode(input logic [3:0] m, input bit early_rdy, output logic [11:0] got);
        int waited;
        waited = 0;
        while (!msg_ready && waited < 20) begin
            tick();
            waited++;
        end
        check("ready_before_accept", {11'd0, msg_ready}, 12'd1);
        msg_in = m;
        msg_valid = 1'b1;
        code_ready = early_rdy;
        tick();
        msg_valid = 1'b0;
        check("ready_low_after_accept", {11'd0, msg_ready}, 12'd0);
        for (int i = 1; i <= 8; i++) begin
            msg_in = 4'($urandom);
            tick();
            check("ready_low_calc", {11'd0, msg_ready}, 12'd0);
            check("busy_calc", {11'd0, busy}, 12'd1);
            check($sformatf("latency_valid_edge%0d", i), {11'd0, code_valid}, (i == 8) ? 12'd1 : 12'd0);
        end
        code_ready = 1'b0;
        got = code;
        $display("encode msg=%b code=%03h code_valid=%0b chk_err=%0b", m, code, code_valid, chk_err);
    endtask

    // Handoff edge with msg_valid held high: must not accept on that edge.
    task automatic handoff(input logic [11:0] exp);
        code_ready = 1'b1;
        msg_valid = 1'b1;
        msg_in = 4'hA;
        tick();
        code_ready = 1'b0;
        check("handoff_valid_clr", {11'd0, code_valid}, 12'd0);
        check("handoff_busy", {11'd0, busy}, 12'd0);
        check("handoff_ready", {11'd0, msg_ready}, 12'd1);
        check("handoff_retain", code, exp);
        check("handoff_chk_clr", {11'd0, chk_err}, 12'd0);
        msg_valid = 1'b0;
        $display("handoff code=%03h busy=%0b msg_ready=%0b", code, busy, msg_ready);
    endtask

    logic [3:0]  vec_msg [4];
    logic [11:0] vec_code [4];
    logic [11:0] got;
    logic [11:0] flipped;

    initial begin
        vec_msg[0] = 4'b0001; vec_code[0] = 12'h629;
        vec_msg[1] = 4'b0100; vec_code[1] = 12'hDEC;
        vec_msg[2] = 4'b1000; vec_code[2] = 12'h990;
        vec_msg[3] = 4'b1111; vec_code[3] = 12'hBFF;

        rst_n = 1'b0;
        msg_in = 4'd0;
        msg_valid = 1'b0;
        code_ready = 1'b0;
        repeat (3) tick();
        check("rst_msg_ready", {11'd0, msg_ready}, 12'd0);
        check("rst_code", code, 12'h000);
        check("rst_code_valid", {11'd0, code_valid}, 12'd0);
        check("rst_busy", {11'd0, busy}, 12'd0);
        check("rst_chk_err", {11'd0, chk_err}, 12'd0);
        $display("reset msg_ready=%0b code=%03h", msg_ready, code);

        rst_n = 1'b1;
        tick();
        check("release_ready", {11'd0, msg_ready}, 12'd1);
        check("release_busy", {11'd0, busy}, 12'd0);

        encode(4'b0000, 1'b0, got);
        check("zero_code", got, 12'h000);
        check("zero_chk_err", {11'd0, chk_err}, 12'd0);
        handoff(12'h000);

        for (int v = 0; v < 4; v++) begin
            encode(vec_msg[v], v[0], got);
            check($sformatf("code_msg%b", vec_msg[v]), got, vec_code[v]);
            check("vec_chk_err", {11'd0, chk_err}, 12'd0);
            handoff(vec_code[v]);
        end

        // Hold in DONE for 20 clocks while the message side toggles.
        encode(4'b0100, 1'b0, got);
        for (int k = 0; k < 20; k++) begin
            msg_in = 4'(k);
            msg_valid = k[0];
            tick();
            check("hold_code", code, 12'hDEC);
            check("hold_valid", {11'd0, code_valid}, 12'd1);
            check("hold_ready", {11'd0, msg_ready}, 12'd0);
        end
        msg_valid = 1'b0;
        $display("hold 20 clocks code=%03h code_valid=%0b", code, code_valid);
        handoff(12'hDEC);

        // Reset at CALC counter=4.
        tick();
        msg_in = 4'b1111;
        msg_valid = 1'b1;
        tick();
        msg_valid = 1'b0;
        repeat (4) tick();
        check("pre_rst_busy", {11'd0, busy}, 12'd1);
        rst_n = 1'b0;
        #2;
        check("midrst_code", code, 12'h000);
        check("midrst_valid", {11'd0, code_valid}, 12'd0);
        check("midrst_busy", {11'd0, busy}, 12'd0);
        check("midrst_ready", {11'd0, msg_ready}, 12'd0);
        check("midrst_chk_err", {11'd0, chk_err}, 12'd0);
        $display("mid-CALC reset code=%03h busy=%0b", code, busy);
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("post_rst_no_output", {11'd0, code_valid}, 12'd0);
        encode(4'b0001, 1'b0, got);
        check("post_rst_code", got, 12'h629);
        handoff(12'h629);

        // All 16 messages with every single-bit error through the syndrome decoder.
        for (int m = 0; m < 16; m++) begin
            encode(4'(m), 1'b0, got);
            check("all_ref", got, enc_ref(4'(m)));
            check("all_synd", {4'd0, synd(got)}, 12'd0);
            check("all_chk_err", {11'd0, chk_err}, 12'd0);
            for (int j = 0; j < 12; j++) begin
                flipped = got ^ (12'd1 << j);
                check($sformatf("decode_m%0d_b%0d", m, j), {8'd0, decode(flipped)}, 12'(m));
            end
            handoff(enc_ref(4'(m)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ldpc_encoder.md
LDPC_ENCODER -- requirements
Module: ldpc_encoder

Interface
REQ-001 The block SHALL have these ports, clock and reset first (name, direction, width, meaning):
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  reset; asynchronous, active-low.
- msg_in  input  4  message word m[3:0].
- msg_valid  input  1  msg_in is valid this cycle.
- msg_ready  output  1  encoder can accept a message.
- code  output  12  encoded codeword c[11:0].
- code_valid  output  1  code holds a complete codeword.
- code_ready  input  1  sink accepts code this cycle.
- busy  output  1  state is not IDLE.
- chk_err  output  1  self-check syndrome is nonzero (see REQ-020).
REQ-002 Reset SHALL be asynchronous, active-low on rst_n; all registers SHALL be clocked on the rising edge of clk.

Function
REQ-003 Codeword map SHALL be (^ is XOR):
- Systematic bits: c4=m3, c2=m2, c1=m1, c0=m0.
- Parity bits: c11=c8=c7=m1^m2^m3; c10=m0^m2; c9=m0; c6=m2; c5=c3=m0^m1^m2.
REQ-004 The 8 parity checks SHALL all be zero for every codeword:
- {11,7}, {11,9,5,4}, {10,6,0}, {10,5,1}
- {10,9,2}, {9,6,3,1}, {8,7,6,2}, {8,4,3,0}
REQ-005 FSM states SHALL be IDLE, CALC and DONE; the reset state SHALL be IDLE.
REQ-006 msg_ready SHALL be 1 only in IDLE; busy SHALL equal (state != IDLE).
REQ-007 In IDLE, a clock edge with msg_valid=1 SHALL latch msg_in, clear the 3-bit parity counter to 0 and enter CALC; msg_valid with msg_ready=0 SHALL be ignored.
REQ-008 In CALC, each edge SHALL compute one parity bit into a working register, in the order c11, c10, c9, c8, c7, c6, c5, c3 for counter values 0..7.
REQ-009 On the edge with counter=7, the block SHALL load code from the working register, set code_valid=1 and enter DONE.
REQ-010 Latency SHALL be 8 clocks from the acceptance edge to code_valid=1.
REQ-011 In DONE, code and code_valid SHALL hold stable until an edge with code_ready=1; that edge SHALL clear code_valid and return to IDLE.
REQ-012 code_ready SHALL be ignored while code_valid=0.
REQ-013 The next message SHALL NOT be accepted on the same edge that completes a handoff; minimum period is 10 clocks per word.
REQ-014 After a handoff, code SHALL retain the last word until the next load.
REQ-015 msg_in changes after acceptance SHALL NOT affect the codeword being computed.

Reset
REQ-016 While rst_n=0, all outputs SHALL be forced to reset values: msg_ready=0, code=12'h000, code_valid=0, busy=0, chk_err=0.
REQ-017 On the first edge after release, msg_ready SHALL be 1.
REQ-018 Reset mid-CALC or mid-DONE SHALL discard the word in progress with no partial output.
REQ-019 After any reset release the FSM SHALL be in IDLE, the counter 0 and the working register 0.

Configuration
REQ-020 With macro LDPC_ENC_SELFCHECK_EN defined, chk_err SHALL be loaded on the same edge as code_valid with the OR of the 8 checks of REQ-004 evaluated on the loaded word, and SHALL clear with code_valid.
REQ-021 Without LDPC_ENC_SELFCHECK_EN, chk_err SHALL be constant 0 and no check logic SHALL be synthesized.

Verification
REQ-022 Reset then msg_in=4'b0000 with valid -> after 8 clocks code=12'h000, code_valid=1, chk_err=0.
REQ-023 Encoding checks:
- 4'b0001 -> 12'h629
- 4'b0100 -> 12'hDEC
- 4'b1000 -> 12'h990
- 4'b1111 -> 12'hBFF
For each: latency exactly 8 clocks and msg_ready=0 throughout.
REQ-024 Hold code_ready=0 for 20 clocks in DONE, toggling msg_in and msg_valid -> code and code_valid stable and no new acceptance; assert code_ready -> IDLE next edge.
REQ-025 Assert rst_n=0 at CALC counter=4 -> outputs zero immediately; after release, a fresh 4'b0001 yields 12'h629.
REQ-026 Encode all 16 messages, flip each single code bit, and feed the system decoder -> decoded msg equals the source in every case; with LDPC_ENC_SELFCHECK_EN, chk_err=0 for all 16 encodes.
